// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI write path between spi_controller
// and the spi_peripheral register block.
//   SPI_FRAME_W      : bits per frame on the wire
//   spi_frame_t      : {wr, addr[6:0], data[7:0]}, wr is sent first
//   SPI_ADDR_*       : peripheral register map
//   spi_ctrl_state_t : controller FSM states
//   spi_max4         : helper used to size the shared phase counter
package spi_pkg;

  localparam int SPI_FRAME_W = 16;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

  localparam logic [6:0] SPI_ADDR_OUT_7_0  = 7'h00;
  localparam logic [6:0] SPI_ADDR_OUT_15_8 = 7'h01;
  localparam logic [6:0] SPI_ADDR_PWM_7_0  = 7'h02;
  localparam logic [6:0] SPI_ADDR_PWM_15_8 = 7'h03;
  localparam logic [6:0] SPI_ADDR_DUTY     = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCLK_HI,
    ST_SCLK_LO,
    ST_HOLD,
    ST_GAP
  } spi_ctrl_state_t;

  function automatic int spi_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_controller.sv
// spi_controller: write-only SPI initiator, mode 0, MSB first.
// Accepts one {addr, wdata} write per start/ready handshake and sends the
// 16-bit frame {1, addr, wdata} with programmable chip-select setup, hold and
// idle spacing. Every pin is driven straight from a flop.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   start in   request valid
//   addr  in   [6:0] target register address
//   wdata in   [7:0] write value
//   ready out  request can be accepted (IDLE)
//   done  out  one-cycle pulse in the first cycle after nCS rises
//   nCS   out  chip select, active low
//   SCLK  out  serial clock, idle low
//   COPI  out  serial data
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int CS_IDLE     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  localparam int MAX_P = spi_max4(HALF_PERIOD, CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int PW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // Phase counter is loaded with (length - 1) on state entry and the state
  // is left when it reads zero, so each state lasts exactly 'length' cycles.
  localparam logic [PW-1:0] LD_HALF  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] LD_SETUP = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] LD_HOLD  = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] LD_IDLE  = PW'(CS_IDLE - 1);

  spi_ctrl_state_t        state_q;
  logic [PW-1:0]          phase_q;
  logic [3:0]             bitcnt_q;
  // Bit 15 goes straight to COPI on accept, so only the remaining 15 bits
  // need to be shifted.
  logic [SPI_FRAME_W-2:0] shift_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   ncs_q;
  logic                   sclk_q;
  logic                   copi_q;

  spi_frame_t frame_d;
  logic       phase_end;

  assign frame_d   = {1'b1, addr, wdata};
  assign phase_end = (phase_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bitcnt_q <= 4'd0;
      shift_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      ncs_q    <= 1'b1;
      sclk_q   <= 1'b0;
      copi_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      phase_q <= phase_q - 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start && ready_q) begin
            state_q  <= ST_SETUP;
            phase_q  <= LD_SETUP;
            shift_q  <= frame_d[SPI_FRAME_W-2:0];
            bitcnt_q <= 4'd15;
            ready_q  <= 1'b0;
            ncs_q    <= 1'b0;
            copi_q   <= frame_d.wr;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            state_q <= ST_SCLK_HI;
            phase_q <= LD_HALF;
            sclk_q  <= 1'b1;
          end
        end
        ST_SCLK_HI: begin
          if (phase_end) begin
            sclk_q <= 1'b0;
            if (bitcnt_q == 4'd0) begin
              state_q <= ST_HOLD;
              phase_q <= LD_HOLD;
            end else begin
              // Next bit appears on the same edge SCLK falls.
              state_q  <= ST_SCLK_LO;
              phase_q  <= LD_HALF;
              copi_q   <= shift_q[SPI_FRAME_W-2];
              shift_q  <= {shift_q[SPI_FRAME_W-3:0], 1'b0};
              bitcnt_q <= bitcnt_q - 4'd1;
            end
          end
        end
        ST_SCLK_LO: begin
          if (phase_end) begin
            state_q <= ST_SCLK_HI;
            phase_q <= LD_HALF;
            sclk_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (phase_end) begin
            state_q <= ST_GAP;
            phase_q <= LD_IDLE;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_end) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          ncs_q   <= 1'b1;
          sclk_q  <= 1'b0;
          copi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign nCS   = ncs_q;
  assign SCLK  = sclk_q;
  assign COPI  = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (HALF_PERIOD 4 and 6) share the
// same request inputs. A timeline model predicts every pin from the cycle
// offset since each accepted request; literal checks pin frame length,
// done/ready timing, decoded frames and reset behaviour.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int T_SETUP = 4;
  localparam int T_HOLD  = 4;
  localparam int T_IDLE  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [1:0] rdy, dn, ncs, sclk, copi;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_controller dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .ready(rdy[0]), .done(dn[0]), .nCS(ncs[0]), .SCLK(sclk[0]), .COPI(copi[0])
  );

  spi_controller #(.HALF_PERIOD(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata),
    .ready(rdy[1]), .done(dn[1]), .nCS(ncs[1]), .SCLK(sclk[1]), .COPI(copi[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int         cyc = 0;
  bit         m_active [2] = '{1'b0, 1'b0};
  int         m_tacc   [2] = '{0, 0};
  logic [15:0] m_frame [2] = '{16'h0, 16'h0};

  function automatic int hp_of(input int i);
    return (i == 0) ? 4 : 6;
  endfunction

  // Cycles from accept until ready is high again.
  function automatic int frame_end(input int hp);
    return T_SETUP + 31 * hp + T_HOLD + 1 + T_IDLE;
  endfunction

  function automatic bit m_ready(input int i);
    return !m_active[i] || ((cyc - m_tacc[i] + 1) >= frame_end(hp_of(i)));
  endfunction

  // {nCS, SCLK, COPI, ready, done} in cycle k after the accept edge (k=1 first).
  function automatic logic [4:0] expect_out(input bit act, input int k, input int hp,
                                            input logic [15:0] f);
    int low_len;
    int m;
    int j;
    low_len = T_SETUP + 31 * hp + T_HOLD;
    if (!act || k >= frame_end(hp)) return 5'b10010;
    if (k > low_len) return {3'b100, 1'b0, (k == low_len + 1)};
    m = k - 1 - T_SETUP;
    if (m < 0) return {2'b00, f[15], 2'b00};
    if (m >= 31 * hp) return {2'b00, f[0], 2'b00};
    j = m / hp;
    return {1'b0, (j % 2 == 0), f[15 - (j + 1) / 2], 2'b00};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m_active[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && m_ready(i)) begin
          m_active[i] <= 1'b1;
          m_tacc[i]   <= cyc + 1;
          m_frame[i]  <= {1'b1, addr, wdata};
        end
      end
    end
  end

  // ---------------- wire monitors and per-cycle compare ----------------
  logic        prev_ncs [2] = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  logic        prev_rdy [2] = '{1'b1, 1'b1};
  int low_len[2], high_len[2], last_low[2], last_high[2];
  int hi_run[2], hi_min[2], hi_max[2], rxn[2], frames[2], dones[2], done_k[2], rdy_k[2];
  logic [15:0] rx[2], last_rx[2];
  logic [7:0]  regs [0:127];

  initial begin
    for (int i = 0; i < 2; i++) begin
      low_len[i] = 0; high_len[i] = 0; last_low[i] = 0; last_high[i] = 0;
      hi_run[i] = 0; hi_min[i] = 0; hi_max[i] = 0; rxn[i] = 0; frames[i] = 0;
      dones[i] = 0; done_k[i] = 0; rdy_k[i] = 0; rx[i] = 0; last_rx[i] = 0;
    end
    for (int r = 0; r < 128; r++) regs[r] = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [4:0] e;
        logic [4:0] a;
        int k;
        k = cyc - m_tacc[i] + 1;
        e = expect_out(m_active[i], k, hp_of(i), m_frame[i]);
        a = {ncs[i], sclk[i], copi[i], rdy[i], dn[i]};
        vectors++;
        if (a !== e) begin
          miscompares++;
          if (miscompares < 40)
            $display("FAIL pins_dut%0d cyc=%0d k=%0d: got %b expected %b (nCS,SCLK,COPI,ready,done)",
                     i, cyc, k, a, e);
        end
        if (ncs[i] == 1'b0) begin
          if (prev_ncs[i]) begin
            last_high[i] = high_len[i];
            low_len[i] = 0; rxn[i] = 0; hi_min[i] = 1000; hi_max[i] = 0;
          end
          low_len[i]++;
        end else begin
          if (!prev_ncs[i]) begin
            last_low[i] = low_len[i];
            high_len[i] = 0;
            if (rxn[i] == 16) begin
              last_rx[i] = rx[i];
              frames[i]++;
              if (i == 0 && rx[i][15]) regs[rx[i][14:8]] = rx[i][7:0];
            end
          end
          high_len[i]++;
        end
        if (sclk[i]) begin
          if (!prev_sclk[i]) begin
            rx[i] = {rx[i][14:0], copi[i]};
            rxn[i]++;
            hi_run[i] = 0;
          end
          hi_run[i]++;
        end else if (prev_sclk[i]) begin
          if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
          if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
        end
        if (dn[i]) begin
          dones[i]++;
          done_k[i] = k;
        end
        if (rdy[i] && !prev_rdy[i]) rdy_k[i] = k;
        prev_ncs[i] = ncs[i]; prev_sclk[i] = sclk[i]; prev_rdy[i] = rdy[i];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (rdy == 2'b11 && ncs == 2'b11) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic pulse_start(input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    wait_idle();
    pulse_start(a, d);
    wait_idle();
  endtask

  initial begin
    int d0, d1, f0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, f0;
    repeat (3) @(negedge clk);
    chk("reset_ncs", ncs, 2'b11);
    chk("reset_sclk", sclk, 2'b00);
    chk("reset_copi", copi, 2'b00);
    chk("reset_ready", rdy, 2'b11);
    chk("reset_done", dn, 2'b00);
    @(posedge clk); #3; rst_n = 1'b1;

    // Single write 0x04 <- 0x80 on both instances.
    d0 = dones[0]; d1 = dones[1];
    do_write(SPI_ADDR_DUTY, 8'h80);
    chk("t1_rx0", last_rx[0], 16'h8480);
    chk("t1_low0", last_low[0], 132);
    chk("t1_done_k0", done_k[0], 133);
    chk("t1_ready_k0", rdy_k[0], 137);
    chk("t1_hi_min0", hi_min[0], 4);
    chk("t1_hi_max0", hi_max[0], 4);
    chk("t1_dones0", dones[0] - d0, 1);
    chk("t1_rx1", last_rx[1], 16'h8480);
    chk("t1_low1", last_low[1], 194);
    chk("t1_hi_min1", hi_min[1], 6);
    chk("t1_hi_max1", hi_max[1], 6);
    chk("t1_dones1", dones[1] - d1, 1);

    // start pulsed while busy must be ignored.
    wait_idle();
    d0 = dones[0];
    pulse_start(SPI_ADDR_PWM_7_0, 8'hF0);
    repeat (47) @(posedge clk);
    pulse_start(7'h55, 8'h33);
    wait_idle();
    chk("t2_rx0", last_rx[0], 16'h82F0);
    chk("t2_rx1", last_rx[1], 16'h82F0);
    chk("t2_dones0", dones[0] - d0, 1);

    // start held high across two requests.
    wait_idle();
    @(posedge clk); #2;
    addr = SPI_ADDR_OUT_15_8; wdata = 8'h5A; start = 1'b1;
    @(posedge clk); #2;
    addr = SPI_ADDR_PWM_15_8; wdata = 8'h0F;
    f0 = frames[0];
    for (int n = 0; n < 1000 && frames[0] == f0; n++) @(negedge clk);
    for (int n = 0; n < 100 && ncs[0] != 1'b0; n++) @(negedge clk);
    chk("t3_second_accept", ncs[0], 0);
    @(posedge clk); #2; start = 1'b0;
    wait_idle();
    chk("t3_gap0", last_high[0], 5);
    chk("t3_rx0", last_rx[0], 16'h830F);
    chk("t3_reg01", regs[SPI_ADDR_OUT_15_8], 8'h5A);
    chk("t3_rx1", last_rx[1], 16'h815A);

    // Reset after the 8th SCLK rise aborts the frame.
    wait_idle();
    d0 = dones[0]; d1 = dones[1]; f0 = frames[0];
    pulse_start(7'h2A, 8'hC3);
    for (int n = 0; n < 200 && rxn[0] != 8; n++) @(negedge clk);
    chk("t4_reached_bit8", rxn[0], 8);
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    chk("t4_async_ncs", ncs, 2'b11);
    chk("t4_async_sclk", sclk, 2'b00);
    chk("t4_async_copi", copi, 2'b00);
    chk("t4_async_ready", rdy, 2'b11);
    chk("t4_async_done", dn, 2'b00);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_no_done0", dones[0] - d0, 0);
    chk("t4_no_done1", dones[1] - d1, 0);
    chk("t4_no_frame0", frames[0] - f0, 0);
    do_write(7'h11, 8'h3C);
    chk("t4_rx0_after", last_rx[0], 16'h913C);
    chk("t4_rx1_after", last_rx[1], 16'h913C);

    // Register-file loopback through the decoded wire frames.
    do_write(SPI_ADDR_OUT_7_0, 8'hA5);
    do_write(SPI_ADDR_OUT_15_8, 8'h5A);
    do_write(SPI_ADDR_PWM_7_0, 8'hF0);
    do_write(SPI_ADDR_PWM_15_8, 8'h0F);
    do_write(SPI_ADDR_DUTY, 8'h80);
    chk("lb_reg00", regs[SPI_ADDR_OUT_7_0], 8'hA5);
    chk("lb_reg01", regs[SPI_ADDR_OUT_15_8], 8'h5A);
    chk("lb_reg02", regs[SPI_ADDR_PWM_7_0], 8'hF0);
    chk("lb_reg03", regs[SPI_ADDR_PWM_15_8], 8'h0F);
    chk("lb_reg04", regs[SPI_ADDR_DUTY], 8'h80);
    chk("lb_rx1", last_rx[1], 16'h8480);
    chk("lb_low1", last_low[1], 194);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
